dpr_fifo_ctrl: RTL

//  Initiator-side controller that drives a synchronous dual-port RAM as a FIFO.

---
 rtl/dpr_fifo_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dpr_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// dpr_fifo_ctrl
//   Drives one external synchronous dual-port RAM as a FIFO. Push/pop requests
//   are turned into combinational RAM strobes and addresses. The RAM's
//   registered dout (1-cycle read latency) is captured into pop_data, and
//   pop_valid is pulsed for one cycle when that capture happens.
//
// Optional feature macro: DPR_FIFO_ERR_EN
//   Defined     : sticky overflow/underflow flags, cleared by rst or flush.
//   Not defined : overflow/underflow are tied low.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   push, push_data       write request and data; push_ready = ~full
//   pop                   read request; pop_ready = ~empty
//   pop_valid, pop_data   one-cycle pulse with the registered read data
//   flush                 synchronous clear; has priority over push and pop
//   count, full, empty    occupancy, 0..MEM_DEPTH
//   overflow, underflow   sticky error flags (optional)
//   ram_*                 RAM interface (blk_sel, wr_en, rd_en, addrs, din, dout)
// ---------------------------------------------------------------------------
module dpr_fifo_ctrl #(
    parameter int MEM_WIDTH = 16,
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [MEM_WIDTH-1:0] push_data,
    output logic                 push_ready,
    input  logic                 pop,
    output logic                 pop_ready,
    output logic                 pop_valid,
    output logic [MEM_WIDTH-1:0] pop_data,
    input  logic                 flush,
    output logic [ADDR_SIZE:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 ram_blk_sel,
    output logic                 ram_wr_en,
    output logic                 ram_rd_en,
    output logic [ADDR_SIZE-1:0] ram_addr_wr,
    output logic [ADDR_SIZE-1:0] ram_addr_rd,
    output logic [MEM_WIDTH-1:0] ram_din,
    input  logic [MEM_WIDTH-1:0] ram_dout
);

    localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE+1)'(MEM_DEPTH);

    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic                 rd_pend;
    logic                 push_acc;
    logic                 pop_acc;

    assign full       = (count == DEPTH_C);
    assign empty      = (count == '0);
    assign push_ready = ~full;
    assign pop_ready  = ~empty;

    // Acceptance only looks at the current flags, so a push while full is
    // refused even if a pop frees a slot on the same edge (and vice versa).
    assign push_acc = push & ~full  & ~flush;
    assign pop_acc  = pop  & ~empty & ~flush;

    assign ram_wr_en   = push_acc;
    assign ram_rd_en   = pop_acc;
    assign ram_blk_sel = push_acc | pop_acc;
    assign ram_addr_wr = wr_ptr;
    assign ram_addr_rd = rd_ptr;
    assign ram_din     = push_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_pend   <= 1'b0;
            pop_valid <= 1'b0;
            pop_data  <= '0;
        end else if (flush) begin
            // Dropping rd_pend here discards the read the RAM is returning.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_pend   <= 1'b0;
            pop_valid <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_acc, pop_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // rd_pend marks the cycle in which the RAM presents read data.
            rd_pend   <= pop_acc;
            pop_valid <= rd_pend;
            if (rd_pend) pop_data <= ram_dout;
        end
    end

`ifdef DPR_FIFO_ERR_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (flush) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (push & full)  ovf_q <= 1'b1;
            if (pop  & empty) unf_q <= 1'b1;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule
